updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised up/down counter with programmable lower/upper limits, variable step, selectable saturate/wrap behaviour, and registered overflow/underflow/config-error pulses. It is the general-purpose successor of the team's fixed 5-bit up/down counter: same load/down/up priority and low/high flags, now at any width and with runtime-configurable bounds. It is used wherever a bounded event or level counter is needed: credit counters, level meters and retry budgets.

## Interface
- WIDTH, 5, counter and limit width (≥2)
- STEP_W, 3, width of step magnitude input (1..WIDTH)
- RESET_VALUE, 0, count value after reset; must lie in [0, 2^WIDTH-1]
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  write cfg_lo/cfg_hi into limit registers
- cfg_lo  in  WIDTH  requested lower limit
- cfg_hi  in  WIDTH  requested upper limit
- wrap_mode  in  1  1 = wrap at limits, 0 = saturate
- load  in  1  load load_value
- load_value  in  WIDTH  value to load
- down  in  1  decrement by step
- up  in  1  increment by step
- step  in  STEP_W  step magnitude; 0 = no change
- count  out  WIDTH  current count (register)
- low  out  1  count == lo_r
- high  out  1  count == hi_r
- ovf  out  1  one-cycle pulse: an up step crossed hi_r
- unf  out  1  one-cycle pulse: a down step crossed lo_r
- cfg_err  out  1  one-cycle pulse: cfg_wr rejected (cfg_lo > cfg_hi)

## Operation
- Reset (async, rst_n=0): count=RESET_VALUE, lo_r=0, hi_r=all-ones, ovf=unf=cfg_err=0.
- Per-edge priority: cfg_wr > load > down > up > hold.
- cfg_wr with cfg_lo ≤ cfg_hi: lo_r←cfg_lo, hi_r←cfg_hi, count←clamp(count, cfg_lo, cfg_hi). load/up/down are ignored that cycle.
- cfg_wr with cfg_lo > cfg_hi: limits and count unchanged, cfg_err pulses, and load/up/down are ignored that cycle.
- load: count←clamp(load_value, lo_r, hi_r). No ovf/unf.
- down (when down=1, regardless of up):
  - Compute with WIDTH+1 bits: t = count − step.
  - If t < lo_r (signed compare on the extended value): unf pulses. The new count is lo_r in saturate mode and hi_r in wrap mode.
  - Otherwise count←t.
- up (when up=1, down=0):
  - Compute t = count + step in WIDTH+1 bits.
  - If t > hi_r: ovf pulses. The new count is hi_r in saturate mode and lo_r in wrap mode.
  - Otherwise count←t.
- Wrap does not carry a residue: the count lands exactly on the opposite limit.
- A step of 0 never changes count and never pulses ovf/unf.
- Saturate at limit:
  - up at count==hi_r with step>0: count stays, ovf pulses.
  - down at count==lo_r with step>0: count stays, unf pulses.
- lo_r==hi_r is legal: count is pinned, low=high=1, and every nonzero step pulses ovf or unf.
- low/high are combinational compares of the registered count against lo_r/hi_r.
- The RTL does not check whether RESET_VALUE lies in [0, all-ones]. After reset, low and high reflect the compare against the reset limits.

## Timing
- count, lo_r, hi_r update on the rising clk edge. Single-cycle latency from input to count.
- low/high are valid in the same cycle as the count they describe, with no added latency.
- ovf/unf/cfg_err are registered. Each is high for exactly the one cycle following the edge that caused it, and back-to-back events produce back-to-back pulses.
- Reset assertion mid-operation immediately forces all reset values, including clearing any pending pulse. Deassertion takes effect at the first rising edge after rst_n rises.
- wrap_mode and step are sampled on the same edge as the operation they affect. A mode change takes effect on that edge.

## Test plan
- **Reset and basic count:** WIDTH=5, reset then up=1, step=1 for 3 cycles -> count 0,1,2,3; low=1 only at count 0; no pulses.
- **Saturate:** lo=0, hi=31, count=30, up, step=4, wrap_mode=0 -> count=31, ovf pulses one cycle, high=1. A further up keeps count=31 and pulses ovf again. down with step=0 -> no change, no pulse.
- **Wrap:** cfg_wr lo=4, hi=20; load 18; up, step=5, wrap_mode=1 -> count=4, ovf=1. Then down, step=1 -> count=20, unf=1.
- **Priority:**
  - load=1, up=1, down=1, load_value=9 -> count=9.
  - up=down=1, step=2 from 9 -> count=7.
  - cfg_wr concurrent with load -> load ignored.
- **Config:**
  - cfg_wr lo=10, hi=5 -> cfg_err pulses and limits stay unchanged.
  - cfg_wr lo=10, hi=15 with count=3 -> count=10, low=1.
  - load 31 -> count=15.
- **Async reset mid-run:** assert rst_n=0 between edges while count=12 and ovf=1 -> count=RESET_VALUE and ovf=0 immediately. Limits return to 0/31.

Source files
------------

// File: rtl/updown_counter_param.sv
// Bounded up/down counter with runtime limits, variable step and saturate/wrap choice.
// Overflow, underflow and rejected-config events are reported as registered one-cycle pulses.
module updown_counter_param #(
   parameter int          WIDTH       = 5,
   parameter int          STEP_W      = 3,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_wr,
   input  logic [WIDTH-1:0]  cfg_lo,
   input  logic [WIDTH-1:0]  cfg_hi,
   input  logic              wrap_mode,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_value,
   input  logic              down,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  count,
   output logic              low,
   output logic              high,
   output logic              ovf,
   output logic              unf,
   output logic              cfg_err
);

   logic [WIDTH-1:0] lo_r, hi_r;
   logic [WIDTH-1:0] count_nx, lo_nx, hi_nx;
   logic             ovf_nx, unf_nx, cfg_err_nx;

   // One extra bit keeps count+step from overflowing and lets count-step go negative.
   logic [WIDTH:0] count_x, step_x, dn_t, up_t;
   logic           dn_under, up_over;

   function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] lo,
                                              input logic [WIDTH-1:0] hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

   assign count_x  = {1'b0, count};
   assign step_x   = (WIDTH+1)'(step);
   assign dn_t     = count_x - step_x;
   assign up_t     = count_x + step_x;
   assign dn_under = $signed(dn_t) < $signed({1'b0, lo_r});
   assign up_over  = up_t > {1'b0, hi_r};

   always_comb begin
      count_nx   = count;
      lo_nx      = lo_r;
      hi_nx      = hi_r;
      ovf_nx     = 1'b0;
      unf_nx     = 1'b0;
      cfg_err_nx = 1'b0;
      if (cfg_wr) begin
         if (cfg_lo <= cfg_hi) begin
            lo_nx    = cfg_lo;
            hi_nx    = cfg_hi;
            count_nx = clamp(count, cfg_lo, cfg_hi);
         end else begin
            cfg_err_nx = 1'b1;
         end
      end else if (load) begin
         count_nx = clamp(load_value, lo_r, hi_r);
      end else if (down) begin
         if (dn_under) begin
            unf_nx   = 1'b1;
            count_nx = wrap_mode ? hi_r : lo_r;
         end else begin
            count_nx = dn_t[WIDTH-1:0];
         end
      end else if (up) begin
         if (up_over) begin
            ovf_nx   = 1'b1;
            count_nx = wrap_mode ? lo_r : hi_r;
         end else begin
            count_nx = up_t[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= WIDTH'(RESET_VALUE);
         lo_r    <= '0;
         hi_r    <= '1;
         ovf     <= 1'b0;
         unf     <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         count   <= count_nx;
         lo_r    <= lo_nx;
         hi_r    <= hi_nx;
         ovf     <= ovf_nx;
         unf     <= unf_nx;
         cfg_err <= cfg_err_nx;
      end
   end

   assign low  = (count == lo_r);
   assign high = (count == hi_r);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=5, STEP_W=3): directed vector table,
// async-reset sequence, then random traffic against an integer reference model.
module tb_updown_counter_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_wr = 1'b0;
   logic [4:0] cfg_lo = '0, cfg_hi = '0;
   logic       wrap_mode = 1'b0, load = 1'b0;
   logic [4:0] load_value = '0;
   logic       down = 1'b0, up = 1'b0;
   logic [2:0] step = '0;
   logic [4:0] count;
   logic       low, high, ovf, unf, cfg_err;

   int tests = 0;
   int fails = 0;

   updown_counter_param #(.WIDTH(5), .STEP_W(3), .RESET_VALUE(0)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
      .wrap_mode(wrap_mode), .load(load), .load_value(load_value), .down(down),
      .up(up), .step(step), .count(count), .low(low), .high(high), .ovf(ovf),
      .unf(unf), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       cfg_wr;
      logic [4:0] cfg_lo, cfg_hi;
      logic       wrap, load;
      logic [4:0] lv;
      logic       down, up;
      logic [2:0] step;
      logic [4:0] e_count;
      logic       e_low, e_high, e_ovf, e_unf, e_cerr;
   } vec_t;

   vec_t vq[$];
   logic [9:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [9:0] e);
      check({tag, ".count"},   count,   e[9:5]);
      check({tag, ".low"},     low,     e[4]);
      check({tag, ".high"},    high,    e[3]);
      check({tag, ".ovf"},     ovf,     e[2]);
      check({tag, ".unf"},     unf,     e[1]);
      check({tag, ".cfg_err"}, cfg_err, e[0]);
   endtask

   task automatic add(input logic c, input int lo, input int hi, input logic w,
                      input logic ld, input int lv, input logic dn, input logic u,
                      input int st, input int ec, input logic el, input logic eh,
                      input logic eo, input logic eu, input logic ee);
      vec_t v;
      v.cfg_wr = c; v.cfg_lo = 5'(lo); v.cfg_hi = 5'(hi); v.wrap = w; v.load = ld;
      v.lv = 5'(lv); v.down = dn; v.up = u; v.step = 3'(st); v.e_count = 5'(ec);
      v.e_low = el; v.e_high = eh; v.e_ovf = eo; v.e_unf = eu; v.e_cerr = ee;
      vq.push_back(v);
   endtask

   task automatic drive(input logic c, input logic [4:0] lo, input logic [4:0] hi,
                        input logic w, input logic ld, input logic [4:0] lv,
                        input logic dn, input logic u, input logic [2:0] st);
      cfg_wr = c; cfg_lo = lo; cfg_hi = hi; wrap_mode = w; load = ld;
      load_value = lv; down = dn; up = u; step = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer arithmetic on the counter's rules.
   int m_cnt, m_lo, m_hi;
   logic m_ovf, m_unf, m_cerr;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic model_step(input logic c, input int lo, input int hi, input logic w,
                             input logic ld, input int lv, input logic dn,
                             input logic u, input int st);
      int t;
      m_ovf = 0; m_unf = 0; m_cerr = 0;
      if (c) begin
         if (lo <= hi) begin m_lo = lo; m_hi = hi; m_cnt = clampi(m_cnt, lo, hi); end
         else m_cerr = 1;
      end else if (ld) begin
         m_cnt = clampi(lv, m_lo, m_hi);
      end else if (dn) begin
         t = m_cnt - st;
         if (t < m_lo) begin m_unf = 1; m_cnt = w ? m_hi : m_lo; end
         else m_cnt = t;
      end else if (u) begin
         t = m_cnt + st;
         if (t > m_hi) begin m_ovf = 1; m_cnt = w ? m_lo : m_hi; end
         else m_cnt = t;
      end
   endtask

   function automatic logic [9:0] model_pack();
      return {5'(m_cnt), m_cnt == m_lo, m_cnt == m_hi, m_ovf, m_unf, m_cerr};
   endfunction

   initial begin
      //  cfg lo hi  w  ld lv dn up st  cnt low hi ovf unf err
      add(0, 0, 0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1,   2, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1,   3, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1,30, 0, 0, 0,  30, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 4,  31, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 4,  31, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0,  31, 0, 1, 0, 0, 0);
      add(1, 4,20, 0, 0, 0, 0, 0, 0,  20, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1,18, 0, 0, 0,  18, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1, 5,   4, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0, 1,  20, 0, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 9, 1, 1, 3,   9, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 2,   7, 0, 0, 0, 0, 0);
      add(1, 4,20, 0, 1,15, 0, 0, 0,   7, 0, 0, 0, 0, 0);
      add(1,10, 5, 0, 0, 0, 0, 0, 0,   7, 0, 0, 0, 0, 1);
      add(1,10, 5, 0, 1, 2, 0, 0, 0,   7, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0, 4,   4, 1, 0, 0, 1, 0);
      add(1, 0,31, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 3, 0, 0, 0,   3, 0, 0, 0, 0, 0);
      add(1,10,15, 0, 0, 0, 0, 0, 0,  10, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1,31, 0, 0, 0,  15, 0, 1, 0, 0, 0);
      add(1,12,12, 0, 0, 0, 0, 0, 0,  12, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1,  12, 1, 1, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0, 1,  12, 1, 1, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 1, 1, 0,  12, 1, 1, 0, 0, 0);

      // Reset state
      rst_n = 1'b0;
      repeat (2) tick();
      check_all("reset", {5'd0, 1'b1, 1'b0, 3'b000});
      rst_n = 1'b1;
      tick();

      foreach (vq[i]) begin
         drive(vq[i].cfg_wr, vq[i].cfg_lo, vq[i].cfg_hi, vq[i].wrap, vq[i].load,
               vq[i].lv, vq[i].down, vq[i].up, vq[i].step);
         tick();
         check_all($sformatf("vec%0d", i),
                   {vq[i].e_count, vq[i].e_low, vq[i].e_high, vq[i].e_ovf,
                    vq[i].e_unf, vq[i].e_cerr});
      end

      // Async reset while ovf is high and count is 12
      drive(1, 5'd0, 5'd12, 0, 0, 5'd0, 0, 0, 3'd0); tick();
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 3'd1);  tick();
      check_all("pre_rst", {5'd12, 1'b0, 1'b1, 3'b100});
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 3'd0);
      #2 rst_n = 1'b0;
      #1 check_all("async_rst", {5'd0, 1'b1, 1'b0, 3'b000});
      #1 rst_n = 1'b1;
      drive(0, 5'd0, 5'd0, 0, 1, 5'd31, 0, 0, 3'd0); tick();
      check_all("rst_limits", {5'd31, 1'b0, 1'b1, 3'b000});

      // Random traffic against the reference model
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 3'd0);
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      m_cnt = 0; m_lo = 0; m_hi = 31;
      for (int n = 0; n < 600; n++) begin
         logic c, w, ld, dn, u;
         logic [4:0] lo, hi, lv;
         logic [2:0] st;
         c  = ($urandom_range(0, 11) == 0);
         lo = 5'($urandom_range(0, 31));
         hi = ($urandom_range(0, 3) == 0) ? lo : 5'($urandom_range(0, 31));
         w  = 1'($urandom_range(0, 1));
         ld = ($urandom_range(0, 9) == 0);
         lv = 5'($urandom_range(0, 31));
         dn = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         st = 3'($urandom_range(0, 7));
         drive(c, lo, hi, w, ld, lv, dn, u, st);
         model_step(c, int'(lo), int'(hi), w, ld, int'(lv), dn, u, int'(st));
         exp_q.push_back(model_pack());
         tick();
         check_all($sformatf("rnd%0d", n), exp_q.pop_front());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
